jh_msg_padder: RTL and testbench
================================

Name: jh_msg_padder

Overview:
Upstream feeder for the JH-512 core. It accepts a byte-oriented message as 64-bit words over a valid/ready stream and packs them into 512-bit blocks. It appends JH padding (a 1 bit, zeros, then the 128-bit big-endian bit length) and issues each block to the core via core_en/core_init/core_idata, waiting for core_fin between blocks. It signals msg_done once the final padded block has been absorbed, at which point the core's digest output is valid.

Parameters:
LEN_W, 64, width of the internal message byte counter; length field bits above LEN_W+3 are driven zero.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_data/in_last/in_bytes valid
in_ready  output  1  padder accepts a word this cycle when in_valid & in_ready
in_data  input  64  message word; in_data[63:56] is the earliest byte
in_last  input  1  word is the final word of the message
in_bytes  input  4  valid bytes in the word, 0..8; meaningful only with in_last (non-last words always carry 8); valid bytes are the most-significant ones
core_en  output  1  one-cycle pulse: core_idata is a block to absorb
core_init  output  1  high with core_en on the first block of a message
core_idata  output  512  block; word k (0..7) at [511-64k -: 64]
core_fin  input  1  core finished the current block (sampled high for ≥1 cycle)
busy  output  1  message in progress (first word accepted through msg_done)
msg_done  output  1  one-cycle pulse after core_fin of the final block

Behaviour:
- Reset (rst_n low at posedge): state FILL, word index 0, byte count 0, first-block flag 1. All outputs 0 except in_ready=1. core_idata is 0.
- Reset mid-operation aborts the message. No core_en is issued after reset until new input arrives.
- FILL:
  - in_ready=1.
  - Each accepted word is written to slot k, and k increments.
  - The byte counter adds 8, or in_bytes on the last word.
  - On a non-last word with k==7: go to ISSUE with next_pad=NONE.
  - On a last word with in_bytes=b:
    - Bytes b..7 of the slot are zeroed.
    - If k==7 and b==8, the block is full: go to ISSUE with next_pad=LEN80.
    - If the total byte count mod 64 is 0 (empty message, or b=0 at k=0): no data block is issued; go directly to PAD with an 0x80 marker.
    - Otherwise, byte 0x80 is placed at the first unused byte position. Remaining slots/bytes are zero. Go to ISSUE with next_pad=LEN.
- ISSUE (1 cycle):
  - core_en=1 and core_idata=block.
  - core_init=first-block flag, which then clears.
  - in_ready=0. Go to WAIT.
- WAIT:
  - in_ready=0.
  - On core_fin: next_pad NONE → FILL with k=0 and block cleared; LEN or LEN80 → PAD; FINAL → DONE.
- PAD (1 cycle, builds the length block):
  - Block is all zero.
  - Byte 0 is 0x80 iff total bytes mod 64 == 0.
  - core_idata[127:0] = total_bytes<<3.
  - Then ISSUE with next_pad=FINAL.
- DONE (1 cycle):
  - msg_done=1, busy drops.
  - Counter, first-block flag and k are reset. Return to FILL.
- Latency:
  - core_en is asserted the cycle after the 8th word is accepted.
  - The PAD block core_en fires 2 cycles after core_fin of the preceding block, or 2 cycles after the last word when no data block is issued.
- busy rises the cycle after the first word is accepted.
- in_valid while in_ready=0 is held by the source; no word is dropped or duplicated.
- in_bytes>8 is illegal; it is treated as 8.
- The byte counter wraps modulo 2^LEN_W. Overflow is not flagged.
- core_fin outside WAIT is ignored.

Test Plan:
- Empty message (in_last=1, in_bytes=0, word at k=0) → single block: core_init=1, idata[511:504]=0x80, idata[127:0]=0, all other bits 0, then msg_done.
- "abc" (one word 0x6162630000000000, last, bytes=3) → block1 idata[511:480]=0x61626380, rest 0, core_init=1. Block2 is all zero except idata[127:0]=0x18, core_init=0.
- 64 bytes (8 full words, last on 8th) → data block issued unchanged. Block2: byte0=0x80, idata[127:0]=0x200.
- 63 bytes (last word bytes=7) → block1 byte63=0x80. Block2 idata[127:0]=0x1F8 with byte0=0x00.
- Backpressure: hold core_fin low for 20 cycles with in_valid=1 → in_ready stays 0, no core_en pulses. After core_fin, next words are accepted in order. A 130-byte message yields 3 blocks with length 0x410.
- Assert rst_n=0 during WAIT of a 2-block message → all outputs return to reset values. A following "abc" message produces the exact "abc" sequence with core_init=1 on its first block.

Source files
------------

// File: rtl/jh_msg_padder.sv
// JH-512 message padder: packs a 64-bit word stream into 512-bit blocks,
// appends the 0x80 marker and 128-bit bit length, and sequences blocks into the core.
module jh_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    input  logic [3:0]   in_bytes,
    output logic         core_en,
    output logic         core_init,
    output logic [511:0] core_idata,
    input  logic         core_fin,
    output logic         busy,
    output logic         msg_done
);

    typedef enum logic [2:0] {FILL, ISSUE, WAIT, PAD, DONE} state_t;
    typedef enum logic [1:0] {PAD_NONE, PAD_LEN, PAD_LEN80, PAD_FINAL} pad_t;

    state_t           state, state_next;
    pad_t             next_pad, pad_next;
    logic [2:0]       k;
    logic [511:0]     block;
    logic [511:0]     fill_block;
    logic [511:0]     pad_block;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_next;
    logic             first;
    logic             accept;
    logic             full_last;
    logic [3:0]       nbytes;
    logic [63:0]      masked;
    logic [5:0]       mark_pos;
    logic [127:0]     len_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FILL;
            next_pad <= PAD_NONE;
        end else begin
            state    <= state_next;
            next_pad <= pad_next;
        end
    end

    always_comb begin
        state_next = state;
        pad_next   = next_pad;
        in_ready   = 1'b0;
        core_en    = 1'b0;
        core_init  = 1'b0;
        core_idata = '0;
        msg_done   = 1'b0;
        accept     = 1'b0;

        // Out-of-range byte counts saturate to a full word.
        nbytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        masked    = in_data & ~(64'hFFFF_FFFF_FFFF_FFFF >> {nbytes, 3'b000});
        mark_pos  = {k, 3'b000} + {2'b00, nbytes};
        full_last = (k == 3'd7) && (nbytes == 4'd8);
        cnt_next  = cnt + (in_last ? LEN_W'(nbytes) : LEN_W'(8));

        fill_block = block;
        fill_block[{3'd7 - k, 6'd0} +: 64] = in_last ? masked : in_data;
        if (in_last && !full_last)
            fill_block = fill_block | (512'(8'h80) << {6'd63 - mark_pos, 3'b000});

        len_bits  = 128'(cnt) << 3;
        pad_block = '0;
        pad_block[127:0] = len_bits;
        if (cnt[5:0] == 6'd0)
            pad_block[511:504] = 8'h80;

        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_last) begin
                        if (full_last) begin
                            state_next = ISSUE;
                            pad_next   = PAD_LEN80;
                        end else if (cnt_next[5:0] == 6'd0) begin
                            // Nothing left to send as data; the length block carries the marker.
                            state_next = PAD;
                        end else begin
                            state_next = ISSUE;
                            pad_next   = PAD_LEN;
                        end
                    end else if (k == 3'd7) begin
                        state_next = ISSUE;
                        pad_next   = PAD_NONE;
                    end
                end
            end
            ISSUE: begin
                core_en    = 1'b1;
                core_init  = first;
                core_idata = block;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_fin) begin
                    case (next_pad)
                        PAD_NONE:  state_next = FILL;
                        PAD_FINAL: state_next = DONE;
                        default:   state_next = PAD;
                    endcase
                end
            end
            PAD: begin
                state_next = ISSUE;
                pad_next   = PAD_FINAL;
            end
            DONE: begin
                msg_done   = 1'b1;
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k     <= '0;
            block <= '0;
            cnt   <= '0;
            first <= 1'b1;
            busy  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        block <= fill_block;
                        k     <= k + 3'd1;
                        cnt   <= cnt_next;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: first <= 1'b0;
                WAIT: begin
                    if (core_fin) begin
                        if (next_pad == PAD_NONE) begin
                            k     <= '0;
                            block <= '0;
                        end
                        if (next_pad == PAD_FINAL)
                            busy <= 1'b0;
                    end
                end
                PAD: block <= pad_block;
                DONE: begin
                    k     <= '0;
                    block <= '0;
                    cnt   <= '0;
                    first <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jh_msg_padder.sv
// Bench for jh_msg_padder: messages are padded by a byte-level JH padding model,
// expected blocks are queued at stimulus time and a monitor compares each core_en/msg_done.
module tb_jh_msg_padder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic [3:0]   in_bytes;
    logic         core_en;
    logic         core_init;
    logic [511:0] core_idata;
    logic         core_fin;
    logic         busy;
    logic         msg_done;

    typedef struct {
        bit           isDone;
        logic [511:0] data;
        bit           init;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] curMsg[$];
    int         checks   = 0;
    int         errors   = 0;
    int         finDelay = 2;

    always #5 clk = ~clk;

    jh_msg_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .core_en    (core_en),
        .core_init  (core_init),
        .core_idata (core_idata),
        .core_fin   (core_fin),
        .busy       (busy),
        .msg_done   (msg_done)
    );

    task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic finishRun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic pushBlock(input logic [511:0] data, input bit init);
        exp_t e;
        e.isDone = 1'b0;
        e.data   = data;
        e.init   = init;
        expQ.push_back(e);
    endtask

    task automatic pushDone();
        exp_t e;
        e.isDone = 1'b1;
        e.data   = '0;
        e.init   = 1'b0;
        expQ.push_back(e);
    endtask

    // Padded message = msg, 0x80, zeros, 16-byte big-endian bit length; total is
    // the smallest multiple of 64 bytes leaving at least 64 bytes of padding.
    task automatic modelPush();
        int         len   = curMsg.size();
        int         total = len + 64 + ((64 - (len % 64)) % 64);
        longint     bits  = longint'(len) * 8;
        logic [7:0] pb[];
        logic [511:0] d;
        pb = new[total];
        foreach (pb[i]) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = curMsg[i];
        pb[len] = 8'h80;
        for (int i = 0; i < 8; i++) pb[total - 1 - i] = 8'(bits >> (8 * i));
        for (int b = 0; b < total / 64; b++) begin
            d = '0;
            for (int j = 0; j < 64; j++) d[511 - 8 * j -: 8] = pb[64 * b + j];
            pushBlock(d, b == 0);
        end
        pushDone();
    endtask

    task automatic randomMsg(input int len);
        curMsg.delete();
        for (int i = 0; i < len; i++) curMsg.push_back(8'($urandom));
    endtask

    // Drives curMsg word by word; extraEmpty appends a trailing last word with 0 bytes.
    task automatic applyStimulus(input bit extraEmpty);
        int          len = curMsg.size();
        int          nwords;
        int          nb;
        int          p;
        int          waited;
        bit          isLast;
        bit          directPad;
        logic [63:0] w;
        if (extraEmpty)    nwords = len / 8 + 1;
        else if (len == 0) nwords = 1;
        else               nwords = (len + 7) / 8;
        for (int wi = 0; wi < nwords; wi++) begin
            isLast = (wi == nwords - 1);
            nb     = isLast ? (len - 8 * wi) : 8;
            for (int i = 0; i < 8; i++) begin
                p = 8 * wi + i;
                w[63 - 8 * i -: 8] = (i < nb) ? curMsg[p] : 8'($urandom);
            end
            in_data  = w;
            in_last  = isLast;
            in_bytes = (isLast && nb == 8 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(9, 15)) : 4'(nb);
            in_valid = 1'b1;
            waited   = 0;
            while (!in_ready) begin
                @(negedge clk);
                waited++;
                if (waited > 500) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL in_ready_timeout got 0 want 1 within 500 cycles");
                    finishRun();
                end
            end
            @(negedge clk);
            in_valid  = 1'b0;
            directPad = isLast && nb == 0 && (wi % 8 == 0);
            if (wi == 0)
                checkOutput("busy_rise", 512'(busy), 512'(1));
            if (directPad) begin
                checkOutput("pad_gap", 512'(core_en), 512'(0));
                @(negedge clk);
                checkOutput("pad_latency", 512'(core_en), 512'(1));
            end else if (isLast || (wi % 8 == 7)) begin
                checkOutput("issue_latency", 512'(core_en), 512'(1));
            end
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 512'(expQ.size()), 512'(0));
        @(negedge clk);
        checkOutput("idle_ready", 512'(in_ready), 512'(1));
        checkOutput("idle_busy", 512'(busy), 512'(0));
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_in_ready", 512'(in_ready), 512'(1));
        checkOutput("rst_core_en", 512'(core_en), 512'(0));
        checkOutput("rst_core_init", 512'(core_init), 512'(0));
        checkOutput("rst_core_idata", core_idata, 512'(0));
        checkOutput("rst_busy", 512'(busy), 512'(0));
        checkOutput("rst_msg_done", 512'(msg_done), 512'(0));
    endtask

    task automatic stallCheck();
        int n = 0;
        while (!core_en && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_first_block", 512'(core_en), 512'(1));
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 512'(in_ready), 512'(0));
            checkOutput("stall_core_en", 512'(core_en), 512'(0));
        end
    endtask

    task automatic sendAbcLiteral();
        curMsg.delete();
        curMsg.push_back(8'h61);
        curMsg.push_back(8'h62);
        curMsg.push_back(8'h63);
        pushBlock({32'h6162_6380, 480'd0}, 1'b1);
        pushBlock({384'd0, 128'h18}, 1'b0);
        pushDone();
        applyStimulus(1'b0);
    endtask

    // Core stand-in: answers every block with a one-cycle core_fin after finDelay cycles.
    initial begin
        core_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && core_en) begin
                repeat (finDelay) @(negedge clk);
                core_fin = 1'b1;
                @(negedge clk);
                core_fin = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every block or completion pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && core_en) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_block got core_en=1 want no block");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("block_kind", 512'(0), 512'(e.isDone));
                    checkOutput("block_data", core_idata, e.data);
                    checkOutput("block_init", 512'(core_init), 512'(e.init));
                end
            end
            if (rst_n && msg_done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done got msg_done=1 want none");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_kind", 512'(1), 512'(e.isDone));
                end
            end
        end
    end

    initial begin
        #500_000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog got timeout want completion");
        finishRun();
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] empty message");
        curMsg.delete();
        pushBlock({8'h80, 504'd0}, 1'b1);
        pushDone();
        applyStimulus(1'b0);
        waitIdle();

        $display("[TB] abc");
        sendAbcLiteral();
        waitIdle();

        $display("[TB] 64 and 63 bytes");
        randomMsg(64);
        modelPush();
        applyStimulus(1'b0);
        waitIdle();
        randomMsg(63);
        modelPush();
        applyStimulus(1'b0);
        waitIdle();

        $display("[TB] 64 bytes closed by an empty last word");
        randomMsg(64);
        modelPush();
        applyStimulus(1'b1);
        waitIdle();

        $display("[TB] 130 bytes with a stalled core");
        finDelay = 20;
        randomMsg(130);
        modelPush();
        fork
            applyStimulus(1'b0);
            stallCheck();
        join
        waitIdle();

        $display("[TB] reset while waiting on the core");
        sendAbcLiteral();
        repeat (5) @(negedge clk);
        checkOutput("wait_in_ready", 512'(in_ready), 512'(0));
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs();
        rst_n = 1'b1;
        expQ.delete();
        repeat (30) @(negedge clk);
        checkResetOutputs();
        finDelay = 3;
        sendAbcLiteral();
        waitIdle();

        $display("[TB] random messages");
        for (int m = 0; m < 12; m++) begin
            finDelay = $urandom_range(1, 4);
            randomMsg($urandom_range(0, 200));
            modelPush();
            applyStimulus(1'b0);
            waitIdle();
        end

        finishRun();
    end

endmodule
